// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types, constants and key-byte helper for the RC4 datapath
package rc4_pkg;

    localparam int SBOX_SIZE   = 256;
    // Widest key the key-byte helper can index; real keys are zero-extended into it.
    localparam int MAX_KEY_LEN = 32;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_WAIT_I,
        ST_CAP_I,
        ST_RD_J,
        ST_WAIT_J,
        ST_CAP_J,
        ST_SWAP,
        ST_WAIT_SWAP,
        ST_NEXT,
        ST_DONE
    } ksa_state_t;

    // Byte k of a key held MSB-byte-first in the low key_len bytes of key.
    // A shift rather than a variable part-select keeps the index arithmetic simple.
    function automatic byte_t key_byte(input logic [8*MAX_KEY_LEN-1:0] key,
                                       input int unsigned              key_len,
                                       input int unsigned              k);
        logic [8*MAX_KEY_LEN-1:0] shifted;
        shifted = key >> (8 * (key_len - 1 - k));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/ksa_fetch_if.sv
// rtl/ksa_fetch_if.sv - S-RAM read port and swap-writer handshake of the KSA fetch block
interface ksa_fetch_if;
    import rc4_pkg::*;

    byte_t mem_address;
    byte_t mem_q;
    logic  mem_owner;
    logic  start_swapping;
    logic  finish_swapping;
    byte_t i_out;
    byte_t j_out;
    byte_t data_i;
    byte_t data_j;

    // master: the fetch block; slave: the RAM plus swap writer side
    modport master (
        output mem_address, mem_owner, start_swapping,
        output i_out, j_out, data_i, data_j,
        input  mem_q, finish_swapping
    );

    modport slave (
        input  mem_address, mem_owner, start_swapping,
        input  i_out, j_out, data_i, data_j,
        output mem_q, finish_swapping
    );

endinterface

// File: rtl/ksa_key_sel.sv
// rtl/ksa_key_sel.sv - combinational key-byte select driven by the key-index counter
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3,
    parameter int KIDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic [8*KEY_LEN-1:0] secret_key,
    input  logic [KIDX_W-1:0]    key_idx,
    output byte_t                key_byte_o
);

    logic [8*MAX_KEY_LEN-1:0] key_ext;

    // Zero-extend the key into the helper's fixed-width view and pick byte key_idx.
    always_comb begin
        key_ext                = '0;
        key_ext[8*KEY_LEN-1:0] = secret_key;
        key_byte_o             = key_byte(key_ext, KEY_LEN, 32'(key_idx));
    end

endmodule

// File: rtl/ksa_fetch.sv
// rtl/ksa_fetch.sv - RC4 key-scheduling read initiator: fetches s[i], s[j] and hands them to the swap writer
module ksa_fetch
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    ksa_fetch_if.master          bus,
    output logic                 busy,
    output logic                 done
);

    localparam int                KIDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam byte_t             LAST_IDX  = byte_t'(SBOX_SIZE - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

    ksa_state_t        state_q, state_d;
    byte_t             i_q, i_d;
    byte_t             j_q, j_d;
    byte_t             data_i_q, data_i_d;
    byte_t             data_j_q, data_j_d;
    byte_t             addr_q, addr_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [1:0]        wait_q, wait_d;
    logic              owner_q, owner_d;
    logic              swap_req_q, swap_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    byte_t             key_b;

    // kidx tracks i mod KEY_LEN so the key byte needs no divider
    ksa_key_sel #(
        .KEY_LEN (KEY_LEN),
        .KIDX_W  (KIDX_W)
    ) u_key_sel (
        .secret_key (secret_key),
        .key_idx    (kidx_q),
        .key_byte_o (key_b)
    );

    // Next-state and datapath updates for one i-step; outputs are derived from the next state
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        data_i_d = data_i_q;
        data_j_d = data_j_q;
        addr_d   = addr_q;
        kidx_d   = kidx_q;
        wait_d   = wait_q;
        owner_d  = owner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = ST_RD_I;
                end
            end
            ST_RD_I: begin
                addr_d  = i_q;
                wait_d  = '0;
                state_d = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CAP_I;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CAP_I: begin
                data_i_d = bus.mem_q;
                j_d      = j_q + bus.mem_q + key_b;
                state_d  = ST_RD_J;
            end
            ST_RD_J: begin
                addr_d  = j_q;
                wait_d  = '0;
                state_d = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CAP_J;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CAP_J: begin
                data_j_d = bus.mem_q;
                state_d  = ST_SWAP;
            end
            ST_SWAP: begin
                // The swap writer takes the RAM port until it reports completion
                owner_d = 1'b0;
                state_d = ST_WAIT_SWAP;
            end
            ST_WAIT_SWAP: begin
                if (bus.finish_swapping) begin
                    owner_d = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (i_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = ST_RD_I;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        swap_req_d = (state_d == ST_SWAP);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    // State and registered outputs; reset abandons any outstanding swap
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            data_i_q   <= '0;
            data_j_q   <= '0;
            addr_q     <= '0;
            kidx_q     <= '0;
            wait_q     <= '0;
            owner_q    <= 1'b1;
            swap_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            data_i_q   <= data_i_d;
            data_j_q   <= data_j_d;
            addr_q     <= addr_d;
            kidx_q     <= kidx_d;
            wait_q     <= wait_d;
            owner_q    <= owner_d;
            swap_req_q <= swap_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_owner      = owner_q;
    assign bus.start_swapping = swap_req_q;
    assign bus.i_out          = i_q;
    assign bus.j_out          = j_q;
    assign bus.data_i         = data_i_q;
    assign bus.data_j         = data_j_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_ksa_fetch.sv
// tb/tb_ksa_fetch.sv - directed scoreboard bench for ksa_fetch at RD_LAT 1 and 3
module tb_ksa_fetch;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic        rst      [2];
    logic        start_v  [2];
    logic [23:0] key_v    [2];
    logic        busy_v   [2];
    logic        done_v   [2];
    logic        fin_resp [2];
    logic        fin_stray[2];
    logic [31:0] rec_v    [2];
    logic        sst_v    [2];
    logic        own_v    [2];
    logic [7:0]  addr_v   [2];

    logic [7:0]  smem [2][256];
    logic [7:0]  ms   [256];
    logic [31:0] logr [2][256];
    logic [31:0] cur_rec [2];
    logic [31:0] eq0 [$];
    logic [31:0] eq1 [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dones[2], swaps[2], dly[2], pend[2], wait_left[2], fin_cyc[2], lat_exp[2];
    int pass_d0[2], pass_s0[2];

    ksa_fetch_if bus1 ();
    ksa_fetch_if bus3 ();

    ksa_fetch #(.KEY_LEN(3), .RD_LAT(1)) dut1 (
        .CLOCK_50   (CLOCK_50),
        .reset      (rst[0]),
        .start      (start_v[0]),
        .secret_key (key_v[0]),
        .bus        (bus1.master),
        .busy       (busy_v[0]),
        .done       (done_v[0])
    );

    ksa_fetch #(.KEY_LEN(3), .RD_LAT(3)) dut3 (
        .CLOCK_50   (CLOCK_50),
        .reset      (rst[1]),
        .start      (start_v[1]),
        .secret_key (key_v[1]),
        .bus        (bus3.master),
        .busy       (busy_v[1]),
        .done       (done_v[1])
    );

    // S-RAM models: 1-stage and 3-stage read pipelines
    logic [7:0] q1;
    logic [7:0] p3 [3];
    always @(posedge CLOCK_50) begin
        q1    <= smem[0][bus1.mem_address];
        p3[0] <= smem[1][bus3.mem_address];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign bus1.mem_q           = q1;
    assign bus3.mem_q           = p3[2];
    assign bus1.finish_swapping = fin_resp[0] | fin_stray[0];
    assign bus3.finish_swapping = fin_resp[1] | fin_stray[1];
    assign rec_v[0]  = {bus1.i_out, bus1.j_out, bus1.data_i, bus1.data_j};
    assign rec_v[1]  = {bus3.i_out, bus3.j_out, bus3.data_i, bus3.data_j};
    assign sst_v[0]  = bus1.start_swapping;
    assign sst_v[1]  = bus3.start_swapping;
    assign own_v[0]  = bus1.mem_owner;
    assign own_v[1]  = bus3.mem_owner;
    assign addr_v[0] = bus1.mem_address;
    assign addr_v[1] = bus3.mem_address;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Software RC4 KSA; pushes the expected {i, j, s[i], s[j]} of each step
    task automatic model_pass(input int w, input logic [23:0] key);
        logic [7:0] j, t, kb;
        j = 8'd0;
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            kb = 8'(key >> (8 * (2 - (n % 3))));
            j  = j + ms[n] + kb;
            if (w == 0) eq0.push_back({8'(n), j, ms[n], ms[j]});
            else        eq1.push_back({8'(n), j, ms[n], ms[j]});
            t = ms[n]; ms[n] = ms[j]; ms[j] = t;
        end
    endtask

    // Swap-writer model and scoreboard for one DUT, run once per cycle
    task automatic service(input int w);
        logic [31:0] e;
        logic [7:0]  a, b, t;
        int          got;
        if (done_v[w]) dones[w]++;
        if (fin_resp[w]) begin
            fin_resp[w] = 1'b0;
            fin_cyc[w]  = cyc;
            pend[w]     = 0;
        end else if (pend[w] != 0) begin
            if (wait_left[w] == 0) begin
                fin_resp[w] = 1'b1;
            end else begin
                wait_left[w]--;
                check($sformatf("hold_owner%0d", w), 32'(own_v[w]), 32'd0);
                check($sformatf("hold_rec%0d", w), rec_v[w], cur_rec[w]);
                check($sformatf("hold_sst%0d", w), 32'(sst_v[w]), 32'd0);
            end
        end
        if (sst_v[w]) begin
            got = 0;
            e   = '0;
            if (w == 0 && eq0.size() > 0) begin e = eq0.pop_front(); got = 1; end
            if (w == 1 && eq1.size() > 0) begin e = eq1.pop_front(); got = 1; end
            check($sformatf("sb_pending%0d", w), 32'(got), 32'd1);
            check($sformatf("sb_rec%0d", w), rec_v[w], e);
            if (rec_v[w][31:24] != 8'd0)
                check($sformatf("step_lat%0d", w), 32'(cyc - fin_cyc[w] + 1), 32'(lat_exp[w]));
            logr[w][rec_v[w][31:24]] = rec_v[w];
            cur_rec[w]   = e;
            a            = rec_v[w][31:24];
            b            = rec_v[w][23:16];
            t            = smem[w][a];
            smem[w][a]   = smem[w][b];
            smem[w][b]   = t;
            swaps[w]++;
            pend[w]      = 1;
            wait_left[w] = dly[w];
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        service(0);
        service(1);
    endtask

    task automatic begin_pass(input int w, input logic [23:0] key, input int delay);
        for (int n = 0; n < 256; n++) smem[w][n] = 8'(n);
        if (w == 0) eq0.delete(); else eq1.delete();
        model_pass(w, key);
        key_v[w]   = key;
        dly[w]     = delay;
        pass_d0[w] = dones[w];
        pass_s0[w] = swaps[w];
        start_v[w] = 1'b1;
        tick();
        start_v[w] = 1'b0;
    endtask

    task automatic end_pass(input int w, input string tag);
        int mism;
        int qs;
        for (int c = 0; c < 8000 && dones[w] == pass_d0[w]; c++) tick();
        repeat (4) tick();
        qs = (w == 0) ? eq0.size() : eq1.size();
        check({tag, "_done_pulses"}, 32'(dones[w] - pass_d0[w]), 32'd1);
        check({tag, "_swaps"}, 32'(swaps[w] - pass_s0[w]), 32'd256);
        check({tag, "_queue_left"}, 32'(qs), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_v[w]), 32'd0);
        mism = 0;
        for (int n = 0; n < 256; n++) if (smem[w][n] !== ms[n]) mism++;
        check({tag, "_sbox_mismatches"}, 32'(mism), 32'd0);
    endtask

    task automatic poll_i(input int w, input logic [7:0] val, input string tag);
        int c;
        c = 0;
        while (c < 3000 && rec_v[w][31:24] != val) begin
            tick();
            c++;
        end
        check(tag, 32'(rec_v[w][31:24]), 32'(val));
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b1; start_v[w] = 1'b0; key_v[w] = '0;
            fin_resp[w] = 1'b0; fin_stray[w] = 1'b0;
            dones[w] = 0; swaps[w] = 0; dly[w] = 0; pend[w] = 0;
            wait_left[w] = 0; fin_cyc[w] = 0; cur_rec[w] = '0;
        end
        lat_exp[0] = 8;
        lat_exp[1] = 12;
        for (int n = 0; n < 256; n++) begin
            smem[0][n] = 8'(n); smem[1][n] = 8'(n);
        end

        // Reset state
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            check($sformatf("rst_addr%0d", w), 32'(addr_v[w]), 32'd0);
            check($sformatf("rst_rec%0d", w), rec_v[w], 32'd0);
            check($sformatf("rst_busy%0d", w), 32'(busy_v[w]), 32'd0);
            check($sformatf("rst_done%0d", w), 32'(done_v[w]), 32'd0);
            check($sformatf("rst_sst%0d", w), 32'(sst_v[w]), 32'd0);
            check($sformatf("rst_owner%0d", w), 32'(own_v[w]), 32'd1);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        // Identity S-box, key 010203
        begin_pass(0, 24'h010203, 0);
        check("t1_busy_after_start", 32'(busy_v[0]), 32'd1);
        end_pass(0, "t1");
        check("t1_step0", logr[0][0], {8'd0, 8'd1, 8'd0, 8'd1});
        check("t1_step1", logr[0][1], {8'd1, 8'd3, 8'd0, 8'd3});

        // All-zero key: two self-swaps first
        begin_pass(0, 24'h000000, 0);
        end_pass(0, "t2");
        check("t2_step0", logr[0][0], {8'd0, 8'd0, 8'd0, 8'd0});
        check("t2_step1", logr[0][1], {8'd1, 8'd1, 8'd1, 8'd1});
        check("t2_step2", logr[0][2], {8'd2, 8'd3, 8'd2, 8'd3});

        // Full pass against software KSA
        begin_pass(0, 24'h000249, 0);
        end_pass(0, "t3");

        // Slow swap writer: outputs held, port released, RD_I right after NEXT
        begin_pass(0, 24'h13579b, 10);
        end_pass(0, "t4");

        // Reset in WAIT_J of step 100, then restart
        begin_pass(0, 24'h010203, 0);
        poll_i(0, 8'd100, "t5_reach_step100");
        repeat (4) tick();
        check("t5_waitj_addr", 32'(addr_v[0]), 32'(eq0[0][23:16]));
        rst[0] = 1'b1;
        tick();
        check("t5_busy", 32'(busy_v[0]), 32'd0);
        check("t5_sst", 32'(sst_v[0]), 32'd0);
        check("t5_owner", 32'(own_v[0]), 32'd1);
        check("t5_i_out", 32'(rec_v[0][31:24]), 32'd0);
        check("t5_done_pulses", 32'(dones[0] - pass_d0[0]), 32'd0);
        rst[0] = 1'b0;
        tick();
        begin_pass(0, 24'h010203, 0);
        end_pass(0, "t5_restart");
        check("t5_restart_step0", logr[0][0], {8'd0, 8'd1, 8'd0, 8'd1});

        // RD_LAT=3: 12-cycle steps, start while busy and stray finish ignored
        begin_pass(1, 24'ha53c7e, 0);
        poll_i(1, 8'd5, "t6_reach_step5");
        check("t6_busy_mid", 32'(busy_v[1]), 32'd1);
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        poll_i(1, 8'd10, "t6_reach_step10");
        fin_stray[1] = 1'b1;
        tick();
        fin_stray[1] = 1'b0;
        end_pass(1, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
